// File: rtl/otp_pkg.sv
// Shared types and constants for the one-time-pad stream sequencer.
// The zero key is treated as "keypad exhausted", never as a usable pad word.
package otp_pkg;

    localparam int WORD_W = 32;
    localparam int BYTE_W = 8;
    localparam int BPW    = WORD_W / BYTE_W;
    localparam int CNT_W  = 16;
    localparam int BCNT_W = 3;

    localparam logic [BYTE_W-1:0] PAD_BYTE  = 8'h20;
    localparam logic [WORD_W-1:0] ZERO_KEY  = 32'h0000_0000;
    localparam logic [BCNT_W-1:0] FULL_CNT  = 3'd4;
    localparam logic [BCNT_W-1:0] LAST_SLOT = 3'd3;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FILL  = 3'd1,
        ST_PAD   = 3'd2,
        ST_KEY   = 3'd3,
        ST_EMIT  = 3'd4,
        ST_ABORT = 3'd5
    } state_e;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        logic [CNT_W-1:0] r;
        if (v == {CNT_W{1'b1}}) begin
            r = v;
        end else begin
            r = v + {{(CNT_W-1){1'b0}}, 1'b1};
        end
        return r;
    endfunction

endpackage

// File: rtl/otp_stream_ctrl_if.sv
// Bundles the byte input, keypad, brickwall and result-word handshakes.
// master is the controller side, slave is the surrounding environment.
interface otp_stream_ctrl_if;
    import otp_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [BYTE_W-1:0] in_byte;
    logic              in_last;
    logic              decrypt;
    logic              key_req;
    logic              key_valid;
    logic [WORD_W-1:0] key_data;
    logic              key_empty;
    logic [WORD_W-1:0] bw_plain;
    logic [WORD_W-1:0] bw_key;
    logic              bw_decrypt;
    logic [WORD_W-1:0] bw_result;
    logic              out_valid;
    logic              out_ready;
    logic [WORD_W-1:0] out_word;
    logic              out_last;
    logic              abort;
    logic              clear_abort;
    logic [CNT_W-1:0]  words_out;

    modport master (
        input  in_valid, in_byte, in_last, decrypt,
        input  key_valid, key_data, key_empty,
        input  bw_result, out_ready, clear_abort,
        output in_ready, key_req, bw_plain, bw_key, bw_decrypt,
        output out_valid, out_word, out_last, abort, words_out
    );

    modport slave (
        output in_valid, in_byte, in_last, decrypt,
        output key_valid, key_data, key_empty,
        output bw_result, out_ready, clear_abort,
        input  in_ready, key_req, bw_plain, bw_key, bw_decrypt,
        input  out_valid, out_word, out_last, abort, words_out
    );

endinterface

// File: rtl/otp_byte_packer.sv
// Big-endian byte packer: each shift moves older bytes toward [31:24],
// so the first byte of a word ends up in the most significant lane.
module otp_byte_packer
    import otp_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              i_shift_en,
    input  logic              i_pad_en,
    input  logic              i_clear,
    input  logic [BYTE_W-1:0] i_byte,
    output logic [WORD_W-1:0] o_word,
    output logic [BCNT_W-1:0] o_cnt,
    output logic              o_full
);

    logic [WORD_W-1:0] r_word;
    logic [BCNT_W-1:0] r_cnt;

    // Shift register and byte count; clear wins over any insert.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_word <= {WORD_W{1'b0}};
            r_cnt  <= {BCNT_W{1'b0}};
        end else if (i_clear) begin
            r_word <= {WORD_W{1'b0}};
            r_cnt  <= {BCNT_W{1'b0}};
        end else if (i_shift_en) begin
            r_word <= {r_word[WORD_W-BYTE_W-1:0], i_byte};
            r_cnt  <= r_cnt + 3'd1;
        end else if (i_pad_en) begin
            r_word <= {r_word[WORD_W-BYTE_W-1:0], PAD_BYTE};
            r_cnt  <= r_cnt + 3'd1;
        end else begin
            r_word <= r_word;
            r_cnt  <= r_cnt;
        end
    end

    assign o_word = r_word;
    assign o_cnt  = r_cnt;
    assign o_full = (r_cnt == FULL_CNT);

endmodule

// File: rtl/otp_stream_ctrl.sv
// One-time-pad stream sequencer: packs bytes into words, fetches one fresh
// key per word, drives the brickwall XOR stage and emits the result word.
module otp_stream_ctrl
    import otp_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    otp_stream_ctrl_if.master  bus
);

    state_e            r_state;
    state_e            w_next;
    logic              r_run;
    logic              r_mode;
    logic              r_msg_last;
    logic [WORD_W-1:0] r_key;
    logic [CNT_W-1:0]  r_words;

    logic              w_in_ready;
    logic              w_accept;
    logic              w_key_bad;
    logic              w_key_ok;
    logic              w_emit_done;
    logic              w_shift;
    logic              w_pad;
    logic              w_clear;
    logic [WORD_W-1:0] w_word;
    logic [BCNT_W-1:0] w_cnt;
    logic              w_full;

    otp_byte_packer u_packer (
        .clk        (clk),
        .reset      (reset),
        .i_shift_en (w_shift),
        .i_pad_en   (w_pad),
        .i_clear    (w_clear),
        .i_byte     (bus.in_byte),
        .o_word     (w_word),
        .o_cnt      (w_cnt),
        .o_full     (w_full)
    );

    // r_run keeps in_ready low while reset is held and for the first edge after.
    assign w_in_ready  = r_run & ((r_state == ST_IDLE) | (r_state == ST_FILL));
    assign w_accept    = bus.in_valid & w_in_ready;
    assign w_key_bad   = bus.key_empty | (bus.key_valid & (bus.key_data == ZERO_KEY));
    assign w_key_ok    = ~bus.key_empty & bus.key_valid & (bus.key_data != ZERO_KEY);
    assign w_emit_done = (r_state == ST_EMIT) & bus.out_ready;

    // Next-state and packer control.
    always_comb begin
        w_next  = r_state;
        w_shift = 1'b0;
        w_pad   = 1'b0;
        w_clear = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_shift = 1'b1;
                    w_next  = bus.in_last ? ST_PAD : ST_FILL;
                end else begin
                    w_next  = ST_IDLE;
                end
            end
            ST_FILL: begin
                if (w_accept) begin
                    w_shift = 1'b1;
                    if (w_cnt == LAST_SLOT) begin
                        w_next = ST_KEY;
                    end else if (bus.in_last) begin
                        w_next = ST_PAD;
                    end else begin
                        w_next = ST_FILL;
                    end
                end else begin
                    w_next = ST_FILL;
                end
            end
            ST_PAD: begin
                w_pad = 1'b1;
                if (w_cnt == LAST_SLOT) begin
                    w_next = ST_KEY;
                end else begin
                    w_next = ST_PAD;
                end
            end
            ST_KEY: begin
                if (w_key_bad) begin
                    w_next = ST_ABORT;
                end else if (w_key_ok && w_full) begin
                    w_next = ST_EMIT;
                end else begin
                    w_next = ST_KEY;
                end
            end
            ST_EMIT: begin
                if (bus.out_ready) begin
                    w_clear = 1'b1;
                    w_next  = r_msg_last ? ST_IDLE : ST_FILL;
                end else begin
                    w_next  = ST_EMIT;
                end
            end
            ST_ABORT: begin
                // The partial word is dropped while parked here.
                w_clear = 1'b1;
                if (bus.clear_abort) begin
                    w_next = ST_IDLE;
                end else begin
                    w_next = ST_ABORT;
                end
            end
            default: begin
                w_clear = 1'b1;
                w_next  = ST_IDLE;
            end
        endcase
    end

    // State register and post-reset enable.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_run   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_run   <= 1'b1;
        end
    end

    // Mode, message-end flag, single-use key register and word counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_mode     <= 1'b0;
            r_msg_last <= 1'b0;
            r_key      <= ZERO_KEY;
            r_words    <= {CNT_W{1'b0}};
        end else begin
            if ((r_state == ST_IDLE) && w_accept) begin
                r_mode <= bus.decrypt;
            end
            if (w_accept) begin
                r_msg_last <= bus.in_last;
            end
            if ((r_state == ST_KEY) && w_key_ok && w_full) begin
                r_key <= bus.key_data;
            end else if (w_emit_done) begin
                r_key <= ZERO_KEY;
            end
            if (w_emit_done) begin
                r_words <= sat_inc(r_words);
            end
        end
    end

    assign bus.in_ready   = w_in_ready;
    assign bus.key_req    = (r_state == ST_KEY);
    assign bus.bw_plain   = w_word;
    assign bus.bw_key     = r_key;
    assign bus.bw_decrypt = r_mode;
    assign bus.out_valid  = (r_state == ST_EMIT);
    assign bus.out_word   = (r_state == ST_EMIT) ? bus.bw_result : {WORD_W{1'b0}};
    assign bus.out_last   = (r_state == ST_EMIT) & r_msg_last;
    assign bus.abort      = (r_state == ST_ABORT);
    assign bus.words_out  = r_words;

endmodule

// File: tb/tb_otp_stream_ctrl.sv
// Directed bench for otp_stream_ctrl with an XOR brickwall model.
module tb_otp_stream_ctrl;

    logic clk;
    logic reset;
    int   total;
    int   bad;
    int   kr_cycles;
    int   k0;
    int   pc;
    int   t;

    otp_stream_ctrl_if bus ();

    assign bus.bw_result = bus.bw_plain ^ bus.bw_key;

    otp_stream_ctrl u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.key_req === 1'b1) kr_cycles++;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send(input logic [7:0] b, input logic last);
        int w;
        w = 0;
        bus.in_valid = 1'b1;
        bus.in_byte  = b;
        bus.in_last  = last;
        while (bus.in_ready !== 1'b1 && w < 40) begin
            @(negedge clk);
            w++;
        end
        chk("send_ready", bus.in_ready, 1'b1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        bus.in_byte  = 8'h00;
    endtask

    task automatic wait_keyreq();
        int w;
        w = 0;
        while (bus.key_req !== 1'b1 && w < 40) begin
            @(negedge clk);
            w++;
        end
        chk("keyreq_seen", bus.key_req, 1'b1);
    endtask

    task automatic give_key(input logic [31:0] k);
        bus.key_valid = 1'b1;
        bus.key_data  = k;
        @(negedge clk);
        bus.key_valid = 1'b0;
        bus.key_data  = 32'h0;
    endtask

    task automatic accept_out();
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    task automatic pulse_clear();
        bus.clear_abort = 1'b1;
        @(negedge clk);
        bus.clear_abort = 1'b0;
    endtask

    initial begin
        total = 0; bad = 0; kr_cycles = 0;
        bus.in_valid = 1'b0; bus.in_byte = 8'h00; bus.in_last = 1'b0;
        bus.decrypt = 1'b0; bus.key_valid = 1'b0; bus.key_data = 32'h0;
        bus.key_empty = 1'b0; bus.out_ready = 1'b0; bus.clear_abort = 1'b0;
        reset = 1'b0;
        tick(2);
        chk("rst_in_ready",  bus.in_ready,  1'b0);
        chk("rst_key_req",   bus.key_req,   1'b0);
        chk("rst_out_valid", bus.out_valid, 1'b0);
        chk("rst_out_word",  bus.out_word,  32'h0);
        chk("rst_abort",     bus.abort,     1'b0);
        chk("rst_words",     bus.words_out, 16'd0);
        chk("rst_bw_plain",  bus.bw_plain,  32'h0);
        chk("rst_bw_key",    bus.bw_key,    32'h0);
        reset = 1'b1;
        tick(2);
        chk("idle_ready", bus.in_ready, 1'b1);

        // "ABCD" single word, encrypt
        k0 = kr_cycles;
        send(8'h41, 1'b0); send(8'h42, 1'b0); send(8'h43, 1'b0); send(8'h44, 1'b1);
        chk("abcd_keyreq_latency", bus.key_req, 1'b1);
        give_key(32'hFFFF0000);
        chk("abcd_out_valid", bus.out_valid, 1'b1);
        chk("abcd_out_word",  bus.out_word,  32'hBEBD4344);
        chk("abcd_out_last",  bus.out_last,  1'b1);
        chk("abcd_bw_dec",    bus.bw_decrypt, 1'b0);
        accept_out();
        chk("abcd_words",   bus.words_out, 16'd1);
        chk("abcd_kr_once", kr_cycles - k0, 1);
        chk("abcd_key_zero", bus.bw_key, 32'h0);

        // "Hi" padded word
        send(8'h48, 1'b0); send(8'h69, 1'b1);
        pc = 0; t = 0;
        while (bus.key_req !== 1'b1 && t < 20) begin
            if (bus.in_ready === 1'b0 && bus.out_valid === 1'b0) pc++;
            @(negedge clk);
            t++;
        end
        chk("hi_pad_cycles", pc, 2);
        wait_keyreq();
        give_key(32'h01010101);
        chk("hi_bw_plain", bus.bw_plain, 32'h48692020);
        chk("hi_out_word", bus.out_word, 32'h49682121);
        accept_out();
        chk("hi_words", bus.words_out, 16'd2);

        // "ABCDEFGH" two words, two keys
        k0 = kr_cycles;
        send(8'h41, 1'b0); send(8'h42, 1'b0); send(8'h43, 1'b0); send(8'h44, 1'b0);
        wait_keyreq();
        give_key(32'h12345678);
        chk("w1_out_word", bus.out_word, 32'h5376153C);
        chk("w1_out_last", bus.out_last, 1'b0);
        tick(3);
        chk("w1_no_early_kr", kr_cycles - k0, 1);
        accept_out();
        send(8'h45, 1'b0); send(8'h46, 1'b0); send(8'h47, 1'b0); send(8'h48, 1'b1);
        wait_keyreq();
        give_key(32'h0F0F0F0F);
        chk("w2_out_word", bus.out_word, 32'h4A494847);
        chk("w2_out_last", bus.out_last, 1'b1);
        accept_out();
        chk("w2_kr_total", kr_cycles - k0, 2);
        chk("w2_words", bus.words_out, 16'd4);

        // keypad empty on second request
        send(8'h41, 1'b0); send(8'h42, 1'b0); send(8'h43, 1'b0); send(8'h44, 1'b0);
        wait_keyreq();
        give_key(32'h11111111);
        chk("ab1_out_word", bus.out_word, 32'h50535255);
        accept_out();
        chk("ab1_words", bus.words_out, 16'd5);
        send(8'h45, 1'b0); send(8'h46, 1'b0); send(8'h47, 1'b0); send(8'h48, 1'b1);
        wait_keyreq();
        bus.key_empty = 1'b1;
        bus.key_valid = 1'b1;
        bus.key_data  = 32'h22222222;
        @(negedge clk);
        bus.key_empty = 1'b0;
        bus.key_valid = 1'b0;
        bus.key_data  = 32'h0;
        chk("ab_abort",    bus.abort,    1'b1);
        chk("ab_key_req",  bus.key_req,  1'b0);
        chk("ab_in_ready", bus.in_ready, 1'b0);
        tick(3);
        chk("ab_no_out",   bus.out_valid, 1'b0);
        chk("ab_sticky",   bus.abort,     1'b1);
        chk("ab_words",    bus.words_out, 16'd5);
        pulse_clear();
        chk("ab_cleared",  bus.abort,    1'b0);
        chk("ab_ready",    bus.in_ready, 1'b1);

        // zero key counts as exhausted
        send(8'h5A, 1'b1);
        wait_keyreq();
        give_key(32'h00000000);
        chk("zk_abort", bus.abort, 1'b1);
        chk("zk_bw_key", bus.bw_key, 32'h0);
        pulse_clear();
        chk("zk_cleared", bus.abort, 1'b0);

        // backpressure, then decrypt round trip
        send(8'h41, 1'b0); send(8'h42, 1'b0); send(8'h43, 1'b0); send(8'h44, 1'b1);
        wait_keyreq();
        give_key(32'hA5A5A5A5);
        k0 = kr_cycles;
        for (int i = 0; i < 10; i++) begin
            bus.clear_abort = (i == 4) ? 1'b1 : 1'b0;
            @(negedge clk);
        end
        bus.clear_abort = 1'b0;
        chk("bp_out_valid", bus.out_valid, 1'b1);
        chk("bp_out_word",  bus.out_word,  32'hE4E7E6E1);
        chk("bp_no_kr",     kr_cycles - k0, 0);
        chk("bp_abort",     bus.abort,     1'b0);
        accept_out();
        bus.decrypt = 1'b1;
        send(8'hE4, 1'b0);
        bus.decrypt = 1'b0;
        send(8'hE7, 1'b0); send(8'hE6, 1'b0); send(8'hE1, 1'b1);
        wait_keyreq();
        give_key(32'hA5A5A5A5);
        chk("dec_out_word", bus.out_word,   32'h41424344);
        chk("dec_mode",     bus.bw_decrypt, 1'b1);
        accept_out();
        chk("dec_words", bus.words_out, 16'd7);

        // reset mid-fill, then fresh message
        send(8'h57, 1'b0); send(8'h58, 1'b0);
        reset = 1'b0;
        #1;
        chk("mr_in_ready", bus.in_ready,  1'b0);
        chk("mr_words",    bus.words_out, 16'd0);
        chk("mr_bw_plain", bus.bw_plain,  32'h0);
        chk("mr_bw_dec",   bus.bw_decrypt, 1'b0);
        tick(2);
        reset = 1'b1;
        tick(2);
        send(8'h57, 1'b0); send(8'h58, 1'b0); send(8'h59, 1'b0); send(8'h5A, 1'b1);
        wait_keyreq();
        give_key(32'h01020304);
        chk("mr_out_word", bus.out_word, 32'h565A5A5E);
        chk("mr_out_last", bus.out_last, 1'b1);
        accept_out();
        chk("mr_words_after", bus.words_out, 16'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/otp_stream_ctrl.md
Name: otp_stream_ctrl

Overview:
Sequencer for the one-time-pad datapath. It accepts a plaintext or ciphertext byte stream and packs it big-endian into 32-bit words, padding the final partial word with spaces. For each word it fetches exactly one fresh key from the keypad store, drives the external brickwall XOR stage, and emits the result word on a valid/ready output. It enforces one-time key use and aborts the message cleanly when the keypad is exhausted.

Parameters:
WORD_W, 32, data and key word width.
BYTE_W, 8, input symbol width; WORD_W/BYTE_W = BPW = 4 bytes per word.
PAD_BYTE, 8'h20, fill byte for a short final word.
CNT_W, 16, width of the emitted-word counter.

Ports:
clk  in  1  system clock; all state updates on rising edge.
reset  in  1  asynchronous, active-low reset (0 = reset asserted).
in_valid  in  1  input byte valid.
in_ready  out  1  controller can accept a byte.
in_byte  in  BYTE_W  input symbol.
in_last  in  1  marks the final byte of a message; qualified by in_valid.
decrypt  in  1  mode; sampled on the first byte of each message.
key_req  out  1  request for the next keypad word.
key_valid  in  1  key_data is valid; sampled only while key_req=1.
key_data  in  WORD_W  keypad word.
key_empty  in  1  keypad exhausted; sampled only while key_req=1.
bw_plain  out  WORD_W  packed word to brickwall.
bw_key  out  WORD_W  key to brickwall.
bw_decrypt  out  1  brickwall mode.
bw_result  in  WORD_W  brickwall output (combinational).
out_valid  out  1  result word valid.
out_ready  in  1  downstream accepts the word.
out_word  out  WORD_W  result word; equals bw_result.
out_last  out  1  marks the last word of the message.
abort  out  1  sticky: message aborted because the keypad was empty.
clear_abort  in  1  single-cycle pulse; clears abort and returns to IDLE.
words_out  out  CNT_W  count of emitted words; saturates at all-ones.

Behaviour:
- Reset values: all outputs 0; packer, key register and mode register 0; state IDLE.
- States: IDLE, FILL, PAD, KEY, EMIT, ABORT.
- in_ready=1 only in IDLE and FILL. A byte is accepted when in_valid & in_ready.
- Packing: the first byte of a word goes to [31:24], the last to [7:0].
- IDLE, byte accepted: latch decrypt into the mode register, store the byte (count=1), go to FILL. If in_last is also set, go directly to PAD.
- FILL, byte accepted:
  - count reaches BPW → KEY.
  - in_last with count<BPW → PAD.
  - Record in_last as msg_last.
- PAD: insert PAD_BYTE, one per cycle, until count=BPW, then → KEY. A 1-byte message takes 3 PAD cycles.
- KEY: key_req=1 (level).
  - key_empty=1, or key_valid=1 with key_data==0: → ABORT. A zero key counts as exhausted. key_empty has priority over key_valid.
  - key_valid=1 with nonzero key_data: latch key_data, → EMIT.
  - Neither asserted: hold.
- EMIT:
  - out_valid=1, out_word=bw_result, out_last=msg_last.
  - bw_plain, bw_key and bw_decrypt are held stable.
  - On out_ready: zeroize the key register, clear the packer, words_out+1 (saturating), then → IDLE if msg_last, else → FILL.
- ABORT: abort=1; in_ready=0, out_valid=0, key_req=0. The partial word is discarded and no key is requested. clear_abort → IDLE, abort=0.
- Latency: 4th byte accepted in cycle N → key_req in N+1. A key_valid in N+1 gives out_valid in N+2. Backpressure holds EMIT indefinitely and never triggers another key_req.
- One-time rule: exactly one key_req handshake per emitted word. The key register is never reused across words.
- Asynchronous reset mid-operation: the partial word and any latched key are lost; words_out returns to 0.
- clear_abort outside ABORT is ignored.

Decomposition:
- Package otp_pkg holds:
  - state enum;
  - WORD_W, BYTE_W, BPW;
  - PAD_BYTE;
  - a zero-key constant.
- Sub-module otp_byte_packer provides the shift-in register, byte count, pad insert and a full flag. The FSM, key handshake and counter stay in otp_stream_ctrl.

Test Plan:
- Bytes "ABCD" with in_last on 'D', decrypt=0, key 32'hFFFF0000 → one output word 32'hBEBD4344 with out_last=1; words_out=1; key_req high for exactly 1 cycle.
- Bytes "Hi" with in_last, key 32'h01010101 → bw_plain=32'h48692020; out_word=32'h49682121; 2 PAD cycles observed.
- 8 bytes "ABCDEFGH", keys K1 then K2 → two words; the second key_req occurs only after the first out_ready; out_last only on word 2.
- key_empty=1 on the second request of an 8-byte message → abort=1; no second out_valid; words_out=1; after clear_abort, in_ready=1 in IDLE.
- out_ready held low 10 cycles in EMIT → out_word stable, no extra key_req; round trip through a decrypt=1 pass with the same key reproduces 32'h41424344.
- reset driven to 0 mid-FILL (2 bytes in) → all outputs 0 immediately; after release, a fresh "WXYZ" message emits correctly.
